rx_polyphase_mf: RTL

Parametrised receive matched filter and symbol decider for the QPSK receive path, one instance per I/Q rail. It holds an NTAPS-deep delay line of oversampled input samples and evaluates the full RRC FIR once per symbol, at the oversampling phase selected by `i_phase`. It registers a hard bit decision plus a valid strobe, and optionally the full-resolution filter output for BER/eye diagnostics. It supersedes the fixed 24-tap, 4x receiver.

---
 rtl/rx_polyphase_mf.sv | 97 +++++++++
 1 files changed

// File: rtl/rx_polyphase_mf.sv
// Receive matched filter with per-symbol decision: NTAPS-deep sample delay line, FIR evaluated
// once per symbol at a selectable oversampling phase. Define RX_FILT_OUT_EN to expose o_filt.
module rx_polyphase_mf #(
    parameter int NTAPS = 24,
    parameter int OS = 4,
    parameter int IN_W = 10,
    parameter int COEF_W = 8,
    parameter int PH_W = 2,
    parameter logic [NTAPS*COEF_W-1:0] COEF = 192'h00FEFF000200FBF5F90A253E483E250AF9F5FB000200FFFE,
    parameter int ACC_W = IN_W + COEF_W + $clog2(NTAPS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic signed [IN_W-1:0] i_rx,
    input  logic [PH_W-1:0]        i_phase,
    output logic                   o_rx,
    output logic                   o_valid
`ifdef RX_FILT_OUT_EN
    ,
    output logic signed [ACC_W-1:0] o_filt
`endif
);

    localparam int PROD_W = IN_W + COEF_W;

    // coef[0] is the most significant slice of the flat vector
    function automatic logic signed [COEF_W-1:0] coef_at(input int k);
        return COEF[(NTAPS-k)*COEF_W-1 -: COEF_W];
    endfunction

    logic signed [IN_W-1:0]   x_p0 [NTAPS];
    logic [PH_W-1:0]          ph_cnt;
    logic                     trig_p0;
    logic signed [PROD_W-1:0] prod_p1 [NTAPS];
    logic                     vld_p1;
    logic signed [ACC_W-1:0]  acc_sum;

    // Stage 0: delay line, phase counter, decision trigger
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) x_p0[k] <= '0;
            ph_cnt  <= '0;
            trig_p0 <= 1'b0;
        end else begin
            trig_p0 <= enable && (ph_cnt == i_phase);
            if (enable) begin
                x_p0[0] <= i_rx;
                for (int k = 1; k < NTAPS; k++) x_p0[k] <= x_p0[k-1];
                ph_cnt <= (ph_cnt == PH_W'(OS-1)) ? '0 : ph_cnt + PH_W'(1);
            end
        end
    end

    // Stage 1: full-width tap products of the line that includes the trigger sample
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) prod_p1[k] <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= trig_p0;
            if (trig_p0) begin
                for (int k = 0; k < NTAPS; k++) prod_p1[k] <= x_p0[k] * coef_at(k);
            end
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int k = 0; k < NTAPS; k++) acc_sum = acc_sum + ACC_W'(prod_p1[k]);
    end

    // Stage 2: sum, sign decision, valid strobe
`ifdef RX_FILT_OUT_EN
    logic signed [ACC_W-1:0] acc_p2;
    assign o_filt = acc_p2;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            o_rx    <= 1'b0;
            o_valid <= 1'b0;
`ifdef RX_FILT_OUT_EN
            acc_p2  <= '0;
`endif
        end else begin
            o_valid <= vld_p1;
            if (vld_p1) begin
                o_rx <= ~acc_sum[ACC_W-1];
`ifdef RX_FILT_OUT_EN
                acc_p2 <= acc_sum;
`endif
            end
        end
    end

endmodule
